// File: rtl/color_seq_game.sv
// Colour-sequence game controller: debounces the sensor colour code, checks each accepted colour
// against a target sequence, and drives the display word and buzzer. Optional macro: COLOR_SEQ_PROG_EN.
module color_seq_game #(
   parameter int                     SEQ_DEPTH   = 4,
   parameter logic [3*SEQ_DEPTH-1:0] DEFAULT_SEQ = 12'h2A3,
   parameter int                     STABLE_CYC  = 50000,
   parameter int                     TONE_HALF   = 25000,
   parameter int                     BEEP_CYC    = 5000000
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       ready_i,
   input  logic       prog_i,
   input  logic [2:0] Color,
   output logic [7:0] Data,
   output logic       Buzzer
);

   localparam int         CNT_W    = $clog2(STABLE_CYC + 1);
   localparam int         TONE_W   = $clog2(4 * TONE_HALF + 1);
   localparam int         DUR_W    = $clog2(2 * BEEP_CYC + 1);
   localparam logic [2:0] IDX_LAST = 3'(SEQ_DEPTH - 1);

   typedef enum logic [2:0] {IDLE, CHECK, BEEP, WIN, LOSE, RELEASE} state_t;

   state_t                 state_q, state_d;
   logic [2:0]             col_q, col_d;
   logic [2:0]             idx_q, idx_d;
   logic [2:0]             last_q, last_d;
   logic [1:0]             status_q, status_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [TONE_W-1:0]      tone_q, tone_d, toneLim;
   logic [DUR_W-1:0]       dur_q, dur_d, durLim;
   logic                   buz_q, buz_d;
   logic                   stable;
   logic                   progMode;
   logic [3*SEQ_DEPTH-1:0] targetVec;
   logic [2:0]             targetCur;

`ifdef COLOR_SEQ_PROG_EN
   logic [3*SEQ_DEPTH-1:0] target_q, target_d;
   assign targetVec = target_q;
   assign progMode  = prog_i;
`else
   // prog_i stays on the pin list for board compatibility but can never select program mode
   assign targetVec = DEFAULT_SEQ;
   assign progMode  = prog_i & 1'b0;
`endif

   assign targetCur = targetVec[3*idx_q +: 3];
   assign stable    = (Color == col_q) && (col_q != 3'b000) && ready_i;
   assign toneLim   = (state_q == LOSE) ? TONE_W'(4 * TONE_HALF - 1) : TONE_W'(TONE_HALF - 1);
   assign durLim    = (state_q == BEEP) ? DUR_W'(BEEP_CYC - 1) : DUR_W'(2 * BEEP_CYC - 1);

   // Next-state and datapath logic; the accept is taken on the edge where cnt reaches STABLE_CYC
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      last_d   = last_q;
      status_d = status_q;
      tone_d   = tone_q;
      dur_d    = dur_q;
      buz_d    = buz_q;
`ifdef COLOR_SEQ_PROG_EN
      target_d = target_q;
`endif
      case (state_q)
         IDLE: begin
            buz_d = 1'b0;
            col_d = Color;
            if (stable) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
                  state_d = CHECK;
               end
            end else begin
               cnt_d = '0;
            end
         end
         CHECK: begin
            last_d = col_q;
            tone_d = '0;
            dur_d  = '0;
            buz_d  = 1'b0;
            if (progMode) begin
`ifdef COLOR_SEQ_PROG_EN
               target_d[3*idx_q +: 3] = col_q;
`endif
               idx_d    = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
               status_d = 2'b11;
               state_d  = BEEP;
            end else if (col_q == targetCur) begin
               if (idx_q == IDX_LAST) begin
                  status_d = 2'b01;
                  state_d  = WIN;
               end else begin
                  idx_d    = idx_q + 3'd1;
                  status_d = 2'b00;
                  state_d  = BEEP;
               end
            end else begin
               status_d = 2'b10;
               state_d  = LOSE;
            end
         end
         // All tone states share the square-wave generator; only half-period and length differ
         BEEP, WIN, LOSE: begin
            if (tone_q == toneLim) begin
               tone_d = '0;
               buz_d  = ~buz_q;
            end else begin
               tone_d = tone_q + TONE_W'(1);
            end
            if (dur_q == durLim) begin
               tone_d  = '0;
               dur_d   = '0;
               buz_d   = 1'b0;
               state_d = RELEASE;
               if (state_q != BEEP) begin
                  idx_d    = 3'd0;
                  status_d = 2'b00;
               end
            end else begin
               dur_d = dur_q + DUR_W'(1);
            end
         end
         // col_q keeps tracking the sensor here so a removed colour is seen before re-arming
         RELEASE: begin
            buz_d = 1'b0;
            col_d = Color;
            if ((col_q == 3'b000) || !ready_i) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset that also reloads the target sequence
   always_ff @(posedge clk) begin
      if (!Reset) begin
         state_q  <= IDLE;
         col_q    <= 3'b000;
         cnt_q    <= '0;
         idx_q    <= 3'd0;
         last_q   <= 3'b000;
         status_q <= 2'b00;
         tone_q   <= '0;
         dur_q    <= '0;
         buz_q    <= 1'b0;
`ifdef COLOR_SEQ_PROG_EN
         target_q <= DEFAULT_SEQ;
`endif
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         status_q <= status_d;
         tone_q   <= tone_d;
         dur_q    <= dur_d;
         buz_q    <= buz_d;
`ifdef COLOR_SEQ_PROG_EN
         target_q <= target_d;
`endif
      end
   end

   assign Data   = {status_q, idx_q, last_q};
   assign Buzzer = buz_q;

endmodule

// File: tb/tb_color_seq_game.sv
// Self-checking bench for color_seq_game: directed scenarios plus randomized presses
// checked against a behavioural game model (target list, index, status, tone shape).
module tb_color_seq_game;

   localparam int          SEQ_DEPTH   = 4;
   localparam logic [11:0] DEFAULT_SEQ = 12'h2A3;
   localparam int          STABLE_CYC  = 3;
   localparam int          TONE_HALF   = 2;
   localparam int          BEEP_CYC    = 8;
`ifdef COLOR_SEQ_PROG_EN
   localparam bit PROG_EN = 1'b1;
`else
   localparam bit PROG_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       Reset;
   logic       ready_i;
   logic       prog_i;
   logic [2:0] Color;
   logic [7:0] Data;
   logic       Buzzer;

   int nCompared   = 0;
   int nMismatched = 0;

   int mTgt[SEQ_DEPTH];
   int mIdx;
   int mLast;
   int mStatus;

   color_seq_game #(
      .SEQ_DEPTH  (SEQ_DEPTH),
      .DEFAULT_SEQ(DEFAULT_SEQ),
      .STABLE_CYC (STABLE_CYC),
      .TONE_HALF  (TONE_HALF),
      .BEEP_CYC   (BEEP_CYC)
   ) dut (
      .clk    (clk),
      .Reset  (Reset),
      .ready_i(ready_i),
      .prog_i (prog_i),
      .Color  (Color),
      .Data   (Data),
      .Buzzer (Buzzer)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] mData();
      logic [7:0] d;
      d = {2'(mStatus), 3'(mIdx), 3'(mLast)};
      return d;
   endfunction

   task automatic modelReset;
      for (int i = 0; i < SEQ_DEPTH; i++) begin
         mTgt[i] = int'((DEFAULT_SEQ >> (3 * i)) & 12'h007);
      end
      mIdx    = 0;
      mLast   = 0;
      mStatus = 0;
   endtask

   // Game rules for one accepted colour: display at check time, tone shape, display after the tone
   task automatic modelAccept(input logic [2:0] col, input logic prog,
                              output logic [7:0] dCheck, output int dur, output int half,
                              output logic [7:0] dAfter);
      bit endRound;
      endRound = 1'b0;
      mLast    = int'(col);
      half     = TONE_HALF;
      dur      = BEEP_CYC;
      if (prog && PROG_EN) begin
         mTgt[mIdx] = int'(col);
         mIdx       = (mIdx + 1) % SEQ_DEPTH;
         mStatus    = 3;
      end else if (int'(col) == mTgt[mIdx]) begin
         if (mIdx == SEQ_DEPTH - 1) begin
            mStatus  = 1;
            dur      = 2 * BEEP_CYC;
            endRound = 1'b1;
         end else begin
            mIdx    = mIdx + 1;
            mStatus = 0;
         end
      end else begin
         mStatus  = 2;
         dur      = 2 * BEEP_CYC;
         half     = 4 * TONE_HALF;
         endRound = 1'b1;
      end
      dCheck = mData();
      if (endRound) begin
         mIdx    = 0;
         mStatus = 0;
      end
      dAfter = mData();
   endtask

   task automatic doReset;
      Reset   = 1'b0;
      Color   = 3'b000;
      ready_i = 1'b1;
      prog_i  = 1'b0;
      tick();
      tick();
      Reset = 1'b1;
      modelReset();
   endtask

   // Presents one colour for 'hold' edges, then removes it and follows the whole response
   task automatic press(input string name, input logic [2:0] col, input int hold,
                        input logic rdy, input logic prog, output logic [7:0] seen);
      logic       acc;
      logic [7:0] prevData, dCheck, dAfter, expD;
      logic       expB;
      int         dur, half, entry, total;
      prevData = mData();
      dCheck   = prevData;
      dAfter   = prevData;
      dur      = 0;
      half     = 1;
      entry    = STABLE_CYC + 2;
      acc      = rdy && (col != 3'b000) && (hold >= STABLE_CYC + 1);
      if (acc) modelAccept(col, prog, dCheck, dur, half, dAfter);
      total = ((hold > entry + dur) ? hold : entry + dur) + 4;
      seen  = 8'h00;
      Color   = col;
      ready_i = rdy;
      prog_i  = prog;
      for (int k = 1; k <= total; k++) begin
         tick();
         if (k == hold) Color = 3'b000;
         if (k == entry) seen = Data;
         if (!acc || k < entry) begin
            expD = prevData;
            expB = 1'b0;
         end else if (k < entry + dur) begin
            expD = dCheck;
            expB = (((k - entry) / half) % 2) != 0;
         end else begin
            expD = dAfter;
            expB = 1'b0;
         end
         nCompared++;
         if (Data !== expD) begin
            nMismatched++;
            $display("[TB] FAIL %s data k=%0d got %h expected %h", name, k, Data, expD);
         end
         nCompared++;
         if (Buzzer !== expB) begin
            nMismatched++;
            $display("[TB] FAIL %s buzzer k=%0d got %b expected %b", name, k, Buzzer, expB);
         end
      end
      ready_i = 1'b1;
      prog_i  = 1'b0;
   endtask

   task automatic test_reset;
      doReset();
      nCompared++;
      if (Data !== 8'h00 || Buzzer !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_initial got %h/%b expected 00/0", Data, Buzzer);
      end
      Color = 3'b011;
      for (int k = 0; k < 7; k++) tick();
      Reset = 1'b0;
      Color = 3'b000;
      tick();
      tick();
      nCompared++;
      if (Data !== 8'h00 || Buzzer !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_midbeep got %h/%b expected 00/0", Data, Buzzer);
      end
      Reset = 1'b1;
      modelReset();
      tick();
   endtask

   task automatic test_win;
      logic [2:0] cols[4];
      logic [7:0] seen;
      cols = '{3'b011, 3'b100, 3'b010, 3'b001};
      doReset();
      for (int i = 0; i < 4; i++) begin
         press("win", cols[i], 5, 1'b1, 1'b0, seen);
         if (i == 0) begin
            nCompared++;
            if (seen !== 8'h0B) begin
               nMismatched++;
               $display("[TB] FAIL win_first got %h expected 0b", seen);
            end
         end
      end
      nCompared++;
      if (seen !== 8'h59) begin
         nMismatched++;
         $display("[TB] FAIL win_check got %h expected 59", seen);
      end
      nCompared++;
      if (Data !== 8'h01) begin
         nMismatched++;
         $display("[TB] FAIL win_after got %h expected 01", Data);
      end
   endtask

   task automatic test_lose;
      logic [7:0] seen;
      doReset();
      press("lose", 3'b011, 5, 1'b1, 1'b0, seen);
      press("lose", 3'b111, 5, 1'b1, 1'b0, seen);
      nCompared++;
      if (seen !== 8'h8F) begin
         nMismatched++;
         $display("[TB] FAIL lose_check got %h expected 8f", seen);
      end
      nCompared++;
      if (Data !== 8'h07) begin
         nMismatched++;
         $display("[TB] FAIL lose_after got %h expected 07", Data);
      end
   endtask

   task automatic test_rejection;
      logic [7:0] seen;
      logic [2:0] glitch[12];
      logic       rdyPat[12];
      doReset();
      press("short_hold", 3'b011, 2, 1'b1, 1'b0, seen);
      press("not_ready", 3'b011, 10, 1'b0, 1'b0, seen);
      // colour change mid-count, then ready dropping mid-count: neither may accept
      glitch = '{3'b011, 3'b011, 3'b100, 3'b100, 3'b100, 3'b000,
                 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b000};
      rdyPat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int k = 0; k < 12; k++) begin
         Color   = glitch[k];
         ready_i = rdyPat[k];
         tick();
         nCompared++;
         if (Data !== 8'h00 || Buzzer !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL glitch k=%0d got %h/%b expected 00/0", k, Data, Buzzer);
         end
      end
      Color   = 3'b000;
      ready_i = 1'b1;
      tick();
      tick();
      press("long_hold", 3'b011, 20, 1'b1, 1'b0, seen);
      nCompared++;
      if (Data !== 8'h0B) begin
         nMismatched++;
         $display("[TB] FAIL long_hold_once got %h expected 0b", Data);
      end
   endtask

   task automatic test_program;
      logic [7:0] seen;
      logic [7:0] expProg[4];
      logic [7:0] expPlay;
      if (PROG_EN) begin
         expProg = '{8'hC9, 8'hD1, 8'hD9, 8'hC1};
         expPlay = 8'h59;
      end else begin
         expProg = '{8'h81, 8'h81, 8'h81, 8'h81};
         expPlay = 8'h81;
      end
      doReset();
      for (int i = 0; i < 4; i++) begin
         press("program", 3'b001, 5, 1'b1, 1'b1, seen);
         nCompared++;
         if (seen !== expProg[i]) begin
            nMismatched++;
            $display("[TB] FAIL program_%0d got %h expected %h", i, seen, expProg[i]);
         end
      end
      for (int i = 0; i < 4; i++) press("prog_play", 3'b001, 5, 1'b1, 1'b0, seen);
      nCompared++;
      if (seen !== expPlay) begin
         nMismatched++;
         $display("[TB] FAIL prog_play got %h expected %h", seen, expPlay);
      end
      doReset();
      press("reload", 3'b011, 5, 1'b1, 1'b0, seen);
      nCompared++;
      if (seen !== 8'h0B) begin
         nMismatched++;
         $display("[TB] FAIL reload got %h expected 0b", seen);
      end
   endtask

   task automatic test_reset_mid_win;
      logic [7:0] seen;
      int         entry;
      entry = STABLE_CYC + 2;
      doReset();
      press("midwin", 3'b011, 5, 1'b1, 1'b0, seen);
      press("midwin", 3'b100, 5, 1'b1, 1'b0, seen);
      press("midwin", 3'b010, 5, 1'b1, 1'b0, seen);
      Color = 3'b001;
      for (int k = 1; k <= entry + 3; k++) begin
         tick();
         if (k == entry) begin
            nCompared++;
            if (Data !== 8'h59) begin
               nMismatched++;
               $display("[TB] FAIL midwin_check got %h expected 59", Data);
            end
         end
      end
      nCompared++;
      if (Buzzer !== ((3 / TONE_HALF) % 2 != 0)) begin
         nMismatched++;
         $display("[TB] FAIL midwin_tone got %b expected %b", Buzzer, ((3 / TONE_HALF) % 2 != 0));
      end
      Reset = 1'b0;
      Color = 3'b000;
      tick();
      nCompared++;
      if (Data !== 8'h00 || Buzzer !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL midwin_reset got %h/%b expected 00/0", Data, Buzzer);
      end
      Reset = 1'b1;
      modelReset();
      tick();
      tick();
      press("after_midwin", 3'b011, 5, 1'b1, 1'b0, seen);
      nCompared++;
      if (seen !== 8'h0B) begin
         nMismatched++;
         $display("[TB] FAIL after_midwin got %h expected 0b", seen);
      end
   endtask

   task automatic test_random;
      logic [7:0] seen;
      logic [2:0] col;
      doReset();
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 0) col = 3'(mTgt[mIdx]);
         else col = 3'($urandom_range(0, 7));
         press("random", col, $urandom_range(1, 8), $urandom_range(0, 5) != 0,
               $urandom_range(0, 3) == 0, seen);
      end
   endtask

   initial begin
      Reset   = 1'b0;
      Color   = 3'b000;
      ready_i = 1'b1;
      prog_i  = 1'b0;
      modelReset();
      test_reset();
      test_win();
      test_lose();
      test_rejection();
      test_program();
      test_reset_mid_win();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
